calculadora_sequenciador: RTL and testbench
===========================================

# calculadora_sequenciador

Byte-serial command front-end that drives the 8-bit combinational calculator block. It collects an opcode byte and two operand bytes over a valid/ready input stream, then presents them to the calculator's A/B/code inputs. It captures the calculator result and returns it over a valid/ready output stream. It is the initiator side of the calculator interface: the calculator is the only consumer of `calc_a`, `calc_b` and `calc_codigo`, and it alone drives `calc_saida`.

## Interface
- `TIMEOUT`, default 255: maximum idle cycles allowed between bytes of one frame; 0 disables the timeout.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  8  input byte (opcode, A or B).
- `in_ready`  out  1  block accepts `in_data`.
- `calc_a`  out  8  operand A to calculator.
- `calc_b`  out  8  operand B to calculator.
- `calc_codigo`  out  3  operation code to calculator.
- `calc_saida`  in  8  calculator result (combinational from `calc_*`).
- `out_valid`  out  1  result available.
- `out_data`  out  8  captured result.
- `out_err`  out  1  frame carried an invalid opcode; qualified by `out_valid`.
- `out_ready`  in  1  consumer accepts result.
- `frame_err`  out  1  one-cycle pulse: frame abandoned on timeout.

## Operation
- Frame format is exactly three accepted bytes, in order: opcode, A, B.
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- Opcode byte: valid values are 0x00–0x04.
  - 0 = zero, 1 = show A, 2 = show B, 3 = A+B, 4 = A−B, both mod 256.
  - Any other byte value sets an internal invalid flag. The opcode stored is then 000.
  - An invalid frame still collects A and B and still produces a response, with `out_err`=1.
- States and transitions:
  - IDLE: `in_ready`=1. Opcode accepted → GET_A.
  - GET_A: `in_ready`=1. A accepted → `calc_a` loaded, go to GET_B.
  - GET_B: `in_ready`=1. B accepted → `calc_b` loaded, `calc_codigo` loaded with the stored opcode, go to EXEC.
  - EXEC: `in_ready`=0. At the next edge: `out_data` ← `calc_saida`, `out_err` ← invalid flag, go to RESP.
  - RESP: `in_ready`=0, `out_valid`=1. On an edge with `out_ready`=1: `out_valid` drops, `calc_codigo` ← 000, go to IDLE.
- `out_data` and `out_err` stay stable while `out_valid`=1.
- `calc_a` and `calc_b` hold their last loaded values between frames.
- Timeout counter:
  - Cleared on every accepted byte and in IDLE, EXEC and RESP.
  - Counts cycles spent in GET_A or GET_B with no byte accepted.
  - When it reaches `TIMEOUT` (and `TIMEOUT`>0): go to IDLE, pulse `frame_err` for one cycle, discard the partial frame. `calc_codigo` is left at 000.
  - Counter width is ceil(log2(`TIMEOUT`+1)), minimum 1.
- If a byte is accepted on the same edge the timeout would fire, the byte wins; no timeout occurs.
- Reset mid-frame or mid-response: all state is dropped immediately and nothing is emitted.

## Timing
- Reset values: state IDLE, `in_ready`=1, `calc_a`=0, `calc_b`=0, `calc_codigo`=000, `out_valid`=0, `out_data`=0, `out_err`=0, `frame_err`=0, counter 0.
- `in_ready` is a registered state decode. It is never asserted in EXEC or RESP.
- B accepted at edge k: `calc_*` are valid after edge k. `out_valid`=1 and `out_data` are valid after edge k+1.
- Back-to-back throughput:
  - With `out_ready` tied high, RESP lasts one cycle.
  - The next opcode can be accepted at edge k+3, giving 5 cycles per frame minimum.
- `out_ready` may be asserted before `out_valid`; only the edge where both are 1 completes the transfer.
- `frame_err` asserts during the cycle following the timeout edge.

## Test plan
- Reset, then bytes 0x03, 0x2A, 0x15 streamed with `out_ready`=1 → `out_data`=0x3F, `out_err`=0, `out_valid` high exactly one cycle, two edges after B accepted.
- Bytes 0x04, 0x10, 0x20 → `out_data`=0xF0 (wrap). Bytes 0x03, 0xFF, 0x02 → `out_data`=0x01.
- Opcodes 0x00, 0x01, 0x02, each with A=0x5A, B=0xA5 → `out_data` is 0x00, 0x5A, 0xA5 respectively. Opcode 0x07 → `out_data`=0x00, `out_err`=1.
- Hold `out_ready`=0 for 10 cycles after a result → `out_valid` and `out_data` stable and `in_ready`=0 throughout. Release → IDLE next cycle, `calc_codigo`=000.
- `TIMEOUT`=4: send opcode and A, then idle → `frame_err` pulses once, back in IDLE. A subsequent full frame 0x03, 0x01, 0x01 → `out_data`=0x02.
- Assert `rst_n` low during GET_B and again during RESP → all outputs return to reset values immediately. No `out_valid` appears afterwards without a new frame.

Source files
------------

// File: rtl/calculadora_sequenciador.sv
// calculadora_sequenciador: byte-serial command front-end for the 8-bit
// combinational calculator. Collects opcode, A, B over a valid/ready stream,
// drives the calculator inputs, captures its result and returns it over a
// valid/ready output stream.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_data/in_ready   input byte stream (opcode, A, B)
//   calc_a/calc_b/calc_codigo   operands and operation code to calculator
//   calc_saida                  calculator result (combinational)
//   out_valid/out_data/out_err  result stream, out_err flags invalid opcode
//   out_ready                   consumer accepts result
//   frame_err                   one-cycle pulse when a frame is abandoned
module calculadora_sequenciador #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] calc_a,
  output logic [7:0] calc_b,
  output logic [2:0] calc_codigo,
  input  logic [7:0] calc_saida,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_err,
  input  logic       out_ready,
  output logic       frame_err
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [7:0]       calc_a_q, calc_a_d;
  logic [7:0]       calc_b_q, calc_b_d;
  logic [2:0]       codigo_q, codigo_d;
  logic [2:0]       op_q, op_d;
  logic             inv_q, inv_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign accept = in_valid & in_ready_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      calc_a_q    <= '0;
      calc_b_q    <= '0;
      codigo_q    <= '0;
      op_q        <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      calc_a_q    <= calc_a_d;
      calc_b_q    <= calc_b_d;
      codigo_q    <= codigo_d;
      op_q        <= op_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      frame_err_q <= frame_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    calc_a_d    = calc_a_q;
    calc_b_d    = calc_b_q;
    codigo_d    = codigo_q;
    op_d        = op_q;
    inv_d       = inv_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    frame_err_d = 1'b0;
    cnt_d       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Out-of-range opcodes run as "zero" and are flagged in the response
          if (in_data > 8'd4) begin
            op_d  = 3'd0;
            inv_d = 1'b1;
          end else begin
            op_d  = in_data[2:0];
            inv_d = 1'b0;
          end
          state_d = S_GET_A;
        end
      end
      S_GET_A, S_GET_B: begin
        if (accept) begin
          if (state_q == S_GET_A) begin
            calc_a_d = in_data;
            state_d  = S_GET_B;
          end else begin
            calc_b_d = in_data;
            codigo_d = op_q;
            state_d  = S_EXEC;
          end
        end else if (TIMEOUT != 0) begin
          // An accepted byte takes priority over an expiring counter
          if (cnt_q == TO_VAL) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            codigo_d    = 3'd0;
            inv_d       = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_EXEC: begin
        out_data_d  = calc_saida;
        out_err_d   = inv_q;
        out_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          codigo_d    = 3'd0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_GET_A) || (state_d == S_GET_B);
  end

  assign in_ready    = in_ready_q;
  assign calc_a      = calc_a_q;
  assign calc_b      = calc_b_q;
  assign calc_codigo = codigo_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_err     = out_err_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_calculadora_sequenciador.sv
// Testbench for calculadora_sequenciador with a behavioural calculator and a
// result scoreboard.
module tb_calculadora_sequenciador;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] calc_a;
  logic [7:0] calc_b;
  logic [2:0] calc_codigo;
  logic [7:0] calc_saida;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_ready;
  logic       frame_err;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb[$];

  calculadora_sequenciador #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .calc_a      (calc_a),
    .calc_b      (calc_b),
    .calc_codigo (calc_codigo),
    .calc_saida  (calc_saida),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_err     (out_err),
    .out_ready   (out_ready),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural calculator
  always_comb begin
    case (calc_codigo)
      3'd1:    calc_saida = calc_a;
      3'd2:    calc_saida = calc_b;
      3'd3:    calc_saida = 8'(calc_a + calc_b);
      3'd4:    calc_saida = 8'(calc_a - calc_b);
      default: calc_saida = 8'h00;
    endcase
  end

  function automatic exp_t model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.err = 1'b0;
    case (op)
      8'h00: e.data = 8'h00;
      8'h01: e.data = a;
      8'h02: e.data = b;
      8'h03: e.data = 8'(a + b);
      8'h04: e.data = 8'(a - b);
      default: begin
        e.data = 8'h00;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Result monitor: every completed output transfer is checked against the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL result_unexpected: got data=%h err=%b, expected no result", out_data, out_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_data !== e.data || out_err !== e.err) begin
          fails++;
          $display("FAIL result: got data=%h err=%b, expected data=%h err=%b",
                   out_data, out_err, e.data, e.err);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL in_ready_wait: in_ready=%b, expected 1 within 50 cycles", in_ready);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input bit push, output int t_op);
    int t;
    if (push) sb.push_back(model(op, a, b));
    send_byte(op, t_op);
    send_byte(a, t);
    send_byte(b, t);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, calc_a, calc_b, calc_codigo, out_valid, out_data, out_err, frame_err}
        !== {1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: got rdy=%b a=%h b=%h cod=%0d ov=%b od=%h oe=%b fe=%b",
               in_ready, calc_a, calc_b, calc_codigo, out_valid, out_data, out_err, frame_err);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic_add();
    int t;
    out_ready = 1'b1;
    sb.push_back(model(8'h03, 8'h2A, 8'h15));
    send_byte(8'h03, t);
    send_byte(8'h2A, t);
    send_byte(8'h15, t);
    // Just after the B edge: operands presented, no result yet
    checks++;
    if ({calc_a, calc_b, calc_codigo, in_ready, out_valid} !== {8'h2A, 8'h15, 3'd3, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL exec_state: got a=%h b=%h cod=%0d rdy=%b ov=%b, expected 2a 15 3 0 0",
               calc_a, calc_b, calc_codigo, in_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: out_valid=%b, expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3F || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL latency_resp: ov=%b od=%h rdy=%b, expected 1 3f 0", out_valid, out_data, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || calc_codigo !== 3'd0) begin
      fails++;
      $display("FAIL resp_one_cycle: ov=%b rdy=%b cod=%0d, expected 0 1 0", out_valid, in_ready, calc_codigo);
    end
  endtask

  task automatic test_ops();
    int t;
    logic [7:0] ops [6] = '{8'h04, 8'h03, 8'h00, 8'h01, 8'h02, 8'h07};
    logic [7:0] as  [6] = '{8'h10, 8'hFF, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    logic [7:0] bs  [6] = '{8'h20, 8'h02, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_frame(ops[i], as[i], bs[i], 1'b1, t);
    drain();
  endtask

  task automatic test_backpressure();
    int t;
    int n = 0;
    int bad = 0;
    out_ready = 1'b0;
    send_frame(8'h03, 8'h01, 8'h02, 1'b1, t);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h03 || out_err !== 1'b0 || in_ready !== 1'b0) begin
        fails++;
        bad++;
        if (bad < 4)
          $display("FAIL hold_stable: ov=%b od=%h oe=%b rdy=%b, expected 1 03 0 0",
                   out_valid, out_data, out_err, in_ready);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || calc_codigo !== 3'd0) begin
      fails++;
      $display("FAIL release_idle: ov=%b rdy=%b cod=%0d, expected 0 1 0", out_valid, in_ready, calc_codigo);
    end
    drain();
  endtask

  task automatic test_timeout();
    int t;
    int pulses = 0;
    out_ready = 1'b1;
    send_byte(8'h03, t);
    send_byte(8'h11, t);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_err === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL timeout_pulse: frame_err high %0d cycles, expected 1", pulses);
    end
    checks++;
    if (in_ready !== 1'b1 || calc_codigo !== 3'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL timeout_idle: rdy=%b cod=%0d ov=%b, expected 1 0 0", in_ready, calc_codigo, out_valid);
    end
    send_frame(8'h03, 8'h01, 8'h01, 1'b1, t);
    drain();
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2;
    out_ready = 1'b1;
    send_frame(8'h03, 8'h01, 8'h02, 1'b1, t0);
    send_frame(8'h04, 8'h05, 8'h01, 1'b1, t1);
    send_frame(8'h01, 8'h77, 8'h00, 1'b1, t2);
    checks++;
    if (t1 - t0 != 5 || t2 - t1 != 5) begin
      fails++;
      $display("FAIL throughput: opcode spacing %0d and %0d cycles, expected 5 and 5", t1 - t0, t2 - t1);
    end
    drain();
  endtask

  task automatic test_reset_mid_frame();
    int t;
    int n = 0;
    int seen = 0;
    out_ready = 1'b1;
    // Reset while waiting for B
    send_byte(8'h01, t);
    send_byte(8'h55, t);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, calc_a, calc_b, calc_codigo, out_valid, out_data, out_err, frame_err}
        !== {1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_get_b: got rdy=%b a=%h b=%h cod=%0d ov=%b od=%h oe=%b fe=%b",
               in_ready, calc_a, calc_b, calc_codigo, out_valid, out_data, out_err, frame_err);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Reset while a result is pending
    out_ready = 1'b0;
    send_frame(8'h02, 8'h33, 8'h44, 1'b0, t);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h44) begin
      fails++;
      $display("FAIL pre_reset_resp: ov=%b od=%h, expected 1 44", out_valid, out_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, calc_a, calc_b, calc_codigo, out_valid, out_data, out_err, frame_err}
        !== {1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_resp: got rdy=%b a=%h b=%h cod=%0d ov=%b od=%h oe=%b fe=%b",
               in_ready, calc_a, calc_b, calc_codigo, out_valid, out_data, out_err, frame_err);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      fails++;
      $display("FAIL no_spurious_result: out_valid high %0d cycles after reset, expected 0", seen);
    end
    // Recovers cleanly with a fresh frame
    send_frame(8'h04, 8'h00, 8'h01, 1'b1, t);
    drain();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    test_reset();
    test_basic_add();
    test_ops();
    test_backpressure();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
